sdf_query_arbiter: RTL

Shares one pipelined SDF query unit among `N_REQ` ray-marcher cores and selects which scene the unit evaluates. The shared unit is an `sdf_query_*` instance, muxed by scene and latency-equalised by the top level to `LATENCY`. The arbiter grants one query per cycle round-robin and caps outstanding queries per requester. It tracks in-flight queries with a tag pipeline and returns each result to the requester that issued it. Scene changes are applied only after the pipeline has drained.

---
 rtl/sdf_query_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/sdf_query_arbiter.sv
// sdf_query_arbiter: round-robin sharing of one pipelined SDF query unit among N_REQ cores,
// with per-requester credit caps, tagged result return and drain-before-switch scene changes.
module sdf_query_arbiter #(
    parameter int N_REQ   = 4,
    parameter int LATENCY = 4,
    parameter int MAX_OUT = 4,
    parameter int FP_W    = 32
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [N_REQ-1:0]          req_valid_in,
    input  logic [N_REQ*3*FP_W-1:0]   req_point_in,
    output logic [N_REQ-1:0]          req_ready_out,
    output logic [3*FP_W-1:0]         sdf_point_out,
    output logic                      sdf_valid_out,
    input  logic [FP_W-1:0]           sdf_in,
    output logic [N_REQ-1:0]          resp_valid_out,
    output logic [FP_W-1:0]           resp_sdf_out,
    input  logic                      scene_req_in,
    input  logic [1:0]                scene_sel_in,
    output logic [1:0]                scene_out,
    output logic                      scene_ack_out,
    output logic                      busy_out,
    output logic [1:0]                dbg_state_out
);
    localparam int IDW = $clog2(N_REQ);
    localparam int CW  = $clog2(MAX_OUT + 1);
    localparam int PW  = 3 * FP_W;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [IDW-1:0]            rr_q, rr_d;
    logic [N_REQ-1:0][CW-1:0]  out_cnt_q, out_cnt_d;
    logic [LATENCY:0]          tag_v_q, tag_v_d;
    logic [LATENCY:0][IDW-1:0] tag_id_q, tag_id_d;
    logic [PW-1:0]             sdf_point_q, sdf_point_d;
    logic                      sdf_valid_q, sdf_valid_d;
    logic [N_REQ-1:0]          resp_valid_q, resp_valid_d;
    logic [FP_W-1:0]           resp_sdf_q, resp_sdf_d;
    logic [1:0]                scene_q, scene_d;
    logic [1:0]                pend_q, pend_d;
    logic                      ack_q, ack_d;

    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] inc;
    logic [N_REQ-1:0] dec;
    logic             found;
    logic             gnt;
    logic [IDW-1:0]   win_id;
    logic [IDW-1:0]   idx;
    logic             out_v;
    logic [IDW-1:0]   out_id;
    logic             pipe_empty;

    // Handshake: a query transfers on any cycle where req_valid_in[i] & req_ready_out[i].
    always_comb begin
        elig   = '0;
        found  = 1'b0;
        win_id = '0;
        idx    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            elig[i] = req_valid_in[i] && (out_cnt_q[i] < CNT_MAX);
        end
        for (int k = 0; k < N_REQ; k++) begin
            idx = IDW'((int'(rr_q) + k) % N_REQ);
            if (!found && elig[idx]) begin
                found  = 1'b1;
                win_id = idx;
            end
        end
        // A scene request in RUN blocks the grant in that very cycle.
        gnt = found && (state_q == ST_RUN) && !scene_req_in && rst_in;
        req_ready_out = '0;
        if (gnt) begin
            req_ready_out[win_id] = 1'b1;
        end
    end

    always_comb begin
        out_v      = tag_v_q[LATENCY];
        out_id     = tag_id_q[LATENCY];
        pipe_empty = !sdf_valid_q && (tag_v_q == '0);

        rr_d        = gnt ? IDW'((int'(win_id) + 1) % N_REQ) : rr_q;
        sdf_valid_d = gnt;
        sdf_point_d = gnt ? req_point_in[int'(win_id)*PW +: PW] : sdf_point_q;

        tag_v_d  = {tag_v_q[LATENCY-1:0], gnt};
        tag_id_d = {tag_id_q[LATENCY-1:0], win_id};

        resp_valid_d = '0;
        resp_sdf_d   = resp_sdf_q;
        if (out_v) begin
            resp_valid_d[out_id] = 1'b1;
            resp_sdf_d           = sdf_in;
        end

        for (int i = 0; i < N_REQ; i++) begin
            inc[i]       = gnt && (win_id == IDW'(i));
            dec[i]       = out_v && (out_id == IDW'(i));
            out_cnt_d[i] = out_cnt_q[i];
            if (inc[i] && !dec[i]) begin
                out_cnt_d[i] = out_cnt_q[i] + CNT_ONE;
            end else if (dec[i] && !inc[i]) begin
                out_cnt_d[i] = out_cnt_q[i] - CNT_ONE;
            end
        end

        state_d = state_q;
        scene_d = scene_q;
        pend_d  = pend_q;
        ack_d   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (scene_req_in) begin
                    pend_d  = scene_sel_in;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The new scene becomes visible together with its ack, once nothing is in flight.
                if (pipe_empty) begin
                    scene_d = pend_q;
                    ack_d   = 1'b1;
                    state_d = ST_SWITCH;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= ST_RUN;
            rr_q         <= '0;
            out_cnt_q    <= '0;
            tag_v_q      <= '0;
            tag_id_q     <= '0;
            sdf_point_q  <= '0;
            sdf_valid_q  <= 1'b0;
            resp_valid_q <= '0;
            resp_sdf_q   <= '0;
            scene_q      <= 2'd0;
            pend_q       <= 2'd0;
            ack_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            out_cnt_q    <= out_cnt_d;
            tag_v_q      <= tag_v_d;
            tag_id_q     <= tag_id_d;
            sdf_point_q  <= sdf_point_d;
            sdf_valid_q  <= sdf_valid_d;
            resp_valid_q <= resp_valid_d;
            resp_sdf_q   <= resp_sdf_d;
            scene_q      <= scene_d;
            pend_q       <= pend_d;
            ack_q        <= ack_d;
        end
    end

    assign sdf_point_out  = sdf_point_q;
    assign sdf_valid_out  = sdf_valid_q;
    assign resp_valid_out = resp_valid_q;
    assign resp_sdf_out   = resp_sdf_q;
    assign scene_out      = scene_q;
    assign scene_ack_out  = ack_q;
    assign busy_out       = (state_q != ST_RUN) || (tag_v_q != '0);
    assign dbg_state_out  = state_q;

endmodule
